// File: rtl/pkt_store_fwd_fifo.sv
// Store-and-forward packet FIFO: buffers whole Avalon-ST packets and releases
// each one only after its endofpacket word is committed; bad packets are discarded.
module pkt_store_fwd_fifo #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 256,
  parameter int DEPTH       = 512,
  parameter int MAX_PKTS    = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [DWIDTH-1:0]               snk_data_i,
  input  logic                            snk_startofpacket_i,
  input  logic                            snk_endofpacket_i,
  input  logic                            snk_valid_i,
  output logic                            snk_ready_o,
  output logic [DWIDTH-1:0]               src_data_o,
  output logic                            src_startofpacket_o,
  output logic                            src_endofpacket_o,
  output logic                            src_valid_o,
  input  logic                            src_ready_i,
  output logic [$clog2(MAX_PKTS+1)-1:0]   pkt_cnt_o,
  output logic [15:0]                     drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKTS + 1);
  localparam int LW = $clog2(MAX_PKT_LEN + 1);
  localparam int EW = DWIDTH + 2;

  // state    | meaning
  // IDLE_W   | between packets, waiting for a sop word
  // IN_PKT_W | packet open, words written past commit_ptr
  // DROP_W   | truncated packet, discarding up to its eop
  typedef enum logic [1:0] {IDLE_W, IN_PKT_W, DROP_W} wstate_e;

  wstate_e         state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   commit_vis_q, rd_ptr_q;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   waddr;
  logic [CW-1:0]   pkt_cnt_q;
  logic [15:0]     drop_cnt_q;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   q_word_q;
  logic            q_valid_q, rdy_en_q;
  logic            full, accept, we, commit_evt, drop_evt;
  logic            do_read, src_take, sent_eop;
  logic            sop, eop;

  assign sop         = snk_startofpacket_i;
  assign eop         = snk_endofpacket_i;
  assign full        = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign snk_ready_o = rdy_en_q && !full && (pkt_cnt_q < CW'(MAX_PKTS));
  assign accept      = snk_valid_i && snk_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE_W;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IN_PKT_W: begin
          if (eop) state_d = IDLE_W;
          else if (!sop && len_q == LW'(MAX_PKT_LEN - 1)) state_d = DROP_W;
        end
        DROP_W: begin
          if (sop && !eop) state_d = IN_PKT_W;
          else if (eop)    state_d = IDLE_W;
        end
        default: if (sop && !eop) state_d = IN_PKT_W;
      endcase
    end
  end

  always_comb begin
    we           = 1'b0;
    waddr        = wr_ptr_q[AW-1:0];
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    commit_evt   = 1'b0;
    drop_evt     = 1'b0;
    if (accept) begin
      case (state_q)
        IN_PKT_W: begin
          if (sop) begin
            // restart: the open packet is abandoned and the new one overwrites it
            we       = 1'b1;
            waddr    = commit_ptr_q[AW-1:0];
            wr_ptr_d = commit_ptr_q + PW'(1);
            len_d    = LW'(1);
            drop_evt = 1'b1;
            if (eop) begin
              commit_ptr_d = commit_ptr_q + PW'(1);
              commit_evt   = 1'b1;
            end
          end else if (eop) begin
            we           = 1'b1;
            wr_ptr_d     = wr_ptr_q + PW'(1);
            commit_ptr_d = wr_ptr_q + PW'(1);
            commit_evt   = 1'b1;
          end else if (len_q == LW'(MAX_PKT_LEN - 1)) begin
            wr_ptr_d = commit_ptr_q;
            drop_evt = 1'b1;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            len_d    = len_q + LW'(1);
          end
        end
        default: begin
          if (sop) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            len_d    = LW'(1);
            if (eop) begin
              commit_ptr_d = wr_ptr_q + PW'(1);
              commit_evt   = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= {sop, eop, snk_data_i};
  end

  // reads track a one-cycle-delayed commit pointer so a new packet is not fetched
  // in the same cycle its eop is written
  assign do_read  = (rd_ptr_q != commit_vis_q) && (!q_valid_q || src_ready_i);
  assign src_take = q_valid_q && src_ready_i;
  assign sent_eop = src_take && q_word_q[DWIDTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdy_en_q     <= 1'b0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      commit_vis_q <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      q_word_q     <= '0;
      q_valid_q    <= 1'b0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      rdy_en_q     <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      commit_vis_q <= commit_ptr_q;
      len_q        <= len_d;
      if (do_read) begin
        q_word_q  <= mem[rd_ptr_q[AW-1:0]];
        q_valid_q <= 1'b1;
        rd_ptr_q  <= rd_ptr_q + PW'(1);
      end else if (src_take) begin
        q_valid_q <= 1'b0;
      end
      case ({commit_evt, sent_eop})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + CW'(1);
        2'b01:   pkt_cnt_q <= pkt_cnt_q - CW'(1);
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
      if (drop_evt && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign src_valid_o         = q_valid_q;
  assign src_data_o          = q_word_q[DWIDTH-1:0];
  assign src_startofpacket_o = q_valid_q && q_word_q[EW-1];
  assign src_endofpacket_o   = q_valid_q && q_word_q[DWIDTH];
  assign pkt_cnt_o           = pkt_cnt_q;
  assign drop_cnt_o          = drop_cnt_q;

endmodule
